// File: rtl/common_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Contents: muldiv_op_t (operation encoding), muldiv_state_t (sequencer
// states), MULDIV_DIV_STEPS (restoring-divider iteration count).
package common_pkg;

    localparam int unsigned MULDIV_DIV_STEPS = 32;

    typedef enum logic [2:0] {
        OP_MUL  = 3'd0,
        OP_MULH = 3'd1,
        OP_DIV  = 3'd2,
        OP_DIVU = 3'd3,
        OP_REM  = 3'd4,
        OP_REMU = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem          in   partial remainder (always < divisor for a non-zero divisor)
//   dividend_bit in   next dividend bit, MSB first
//   divisor      in   unsigned divisor
//   rem_next     out  partial remainder after the trial subtraction
//   quo_bit      out  quotient bit produced by this step
module muldiv_div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         quo_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // Bit W of the difference is the borrow: set only when shifted < divisor.
    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = shifted - {1'b0, divisor};
        quo_bit  = ~diff[W];
        rem_next = quo_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide sequencer for the execute stage.
// Accepts one operation over in_valid/in_ready, runs a one-cycle registered
// multiply or a DIV_STEPS-step restoring divide on magnitudes, and holds the
// sign-corrected result until out_ready.
// Optional macro MULDIV_DIV_SHORTCUT_EN: divide-by-zero and signed overflow
// skip the divider and go straight to DONE.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             operation handshake (in_ready combinational)
//   op, operand_a, operand_b      operation and rs1/rs2 values
//   rd_in                         destination tag
//   flush                         abandon any in-flight operation
//   out_valid/out_ready           result handshake
//   out_result, out_rd            registered result and its tag
//   busy                          unit is not idle (combinational)
module muldiv_unit
    import common_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIV_STEPS  = MULDIV_DIV_STEPS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  muldiv_op_t            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic [4:0]            rd_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_rd,
    output logic                  busy
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned CNT_W = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    muldiv_state_t state, state_d;

    muldiv_op_t        op_q;
    logic [4:0]        rd_q;
    logic [W-1:0]      a_mag, b_mag;
    logic [W-1:0]      quo;        // dividend shifts out MSB-first, quotient shifts in
    logic [W-1:0]      rem;
    logic [CNT_W-1:0]  cnt;
    logic              sign_a, neg_q, div_zero, div_ovf;

    logic              accept;
    logic              in_is_mul, in_is_signed, in_special;
    logic              in_dz, in_ovf;
    logic [W-1:0]      in_a_mag, in_b_mag;
    logic [W-1:0]      step_rem;
    logic              step_q;
    logic [PW-1:0]     prod_mag, prod;

    assign in_ready = (state == S_IDLE) && !flush;
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid && in_ready;

    // Accept-time decode: magnitudes, signedness and RISC-V special cases.
    always_comb begin
        in_is_mul    = (op == OP_MUL) || (op == OP_MULH);
        in_is_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        in_a_mag     = (in_is_signed && operand_a[W-1]) ? -operand_a : operand_a;
        in_b_mag     = (in_is_signed && operand_b[W-1]) ? -operand_b : operand_b;
        in_dz        = !in_is_mul && (operand_b == '0);
        in_ovf       = ((op == OP_DIV) || (op == OP_REM)) &&
                       (operand_a == INT_MIN) && (operand_b == '1);
        in_special   = in_dz || in_ovf;
    end

    muldiv_div_step #(.W(W)) u_step (
        .rem          (rem),
        .dividend_bit (quo[W-1]),
        .divisor      (b_mag),
        .rem_next     (step_rem),
        .quo_bit      (step_q)
    );

    always_comb begin
        prod_mag = PW'(a_mag) * PW'(b_mag);
        prod     = neg_q ? -prod_mag : prod_mag;
    end

    // Sign fix plus divide-by-zero / overflow substitution.
    function automatic logic [W-1:0] div_result(
        input muldiv_op_t o,
        input logic [W-1:0] q,
        input logic [W-1:0] r,
        input logic nq,
        input logic sa,
        input logic dz,
        input logic ov,
        input logic [W-1:0] amag
    );
        logic [W-1:0] qf;
        logic [W-1:0] rf;
        qf = nq ? -q : q;
        rf = sa ? -r : r;
        if (dz) begin
            qf = '1;
            rf = sa ? -amag : amag;   // restores the original dividend
        end else if (ov) begin
            qf = INT_MIN;
            rf = '0;
        end
        return ((o == OP_DIV) || (o == OP_DIVU)) ? qf : rf;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_is_mul) begin
                        state_d = S_MUL;
                    end else begin
`ifdef MULDIV_DIV_SHORTCUT_EN
                        state_d = in_special ? S_DONE : S_DIV;
`else
                        state_d = S_DIV;
`endif
                    end
                end
            end
            S_MUL:  state_d = S_DONE;
            S_DIV:  if (cnt == '0) state_d = S_DONE;
            S_DONE: if (out_valid && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Operand capture, divider iteration and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_MUL;
            rd_q       <= '0;
            a_mag      <= '0;
            b_mag      <= '0;
            quo        <= '0;
            rem        <= '0;
            cnt        <= '0;
            sign_a     <= 1'b0;
            neg_q      <= 1'b0;
            div_zero   <= 1'b0;
            div_ovf    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        rd_q     <= rd_in;
                        a_mag    <= in_a_mag;
                        b_mag    <= in_b_mag;
                        quo      <= in_a_mag;
                        rem      <= '0;
                        cnt      <= CNT_W'(DIV_STEPS - 1);
                        sign_a   <= in_is_signed && operand_a[W-1];
                        neg_q    <= in_is_signed && (operand_a[W-1] ^ operand_b[W-1]);
                        div_zero <= in_dz;
                        div_ovf  <= in_ovf;
                    end
                end
                S_MUL: begin
                    out_result <= (op_q == OP_MULH) ? prod[PW-1:W] : prod[W-1:0];
                    out_rd     <= rd_q;
                    out_valid  <= 1'b1;
                end
                S_DIV: begin
                    rem <= step_rem;
                    quo <= {quo[W-2:0], step_q};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        out_result <= div_result(op_q, {quo[W-2:0], step_q}, step_rem,
                                                 neg_q, sign_a, div_zero, div_ovf, a_mag);
                        out_rd     <= rd_q;
                        out_valid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Entered without a result only via the special-case shortcut.
                    if (!out_valid) begin
                        out_result <= div_result(op_q, '0, '0, neg_q, sign_a,
                                                 div_zero, div_ovf, a_mag);
                        out_rd     <= rd_q;
                        out_valid  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import common_pkg::*;

`ifdef MULDIV_DIV_SHORTCUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    muldiv_op_t  op;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .rd_in      (rd_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation with out_ready high; check latency, result, tag, return to idle.
    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int n;
        op        = o;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        in_valid  = 1'b1;
        #1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " result"}, out_result, exp);
        check({tag, " rd"}, 32'(out_rd), 32'(rd));
        tick();
        check({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] held_result;
        logic        saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = OP_MUL;
        operand_a = '0;
        operand_b = '0;
        rd_in     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_result", out_result, 32'd0);
        check("rst out_rd", 32'(out_rd), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("mul",      OP_MUL,  32'd7,        32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 2);
        run_op("mulh",     OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 2);
        run_op("mulh_neg", OP_MULH, 32'hFFFF_FFFE, 32'd3,        5'd3,  32'hFFFF_FFFF, 2);
        run_op("div",      OP_DIV,  32'hFFFF_FFEC, 32'd3,        5'd4,  32'hFFFF_FFFA, 33);
        run_op("rem",      OP_REM,  32'hFFFF_FFEC, 32'd3,        5'd5,  32'hFFFF_FFFE, 33);
        run_op("divu",     OP_DIVU, 32'hFFFF_FFFF, 32'd2,        5'd6,  32'h7FFF_FFFF, 33);
        run_op("remu",     OP_REMU, 32'd100,      32'd7,        5'd7,  32'd2,         33);
        run_op("div_z",    OP_DIV,  32'd5,        32'd0,        5'd8,  32'hFFFF_FFFF, SPECIAL_LAT);
        run_op("rem_z",    OP_REM,  32'd5,        32'd0,        5'd9,  32'd5,         SPECIAL_LAT);
        run_op("rem_zneg", OP_REM,  32'hFFFF_FFFB, 32'd0,       5'd10, 32'hFFFF_FFFB, SPECIAL_LAT);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, SPECIAL_LAT);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,       SPECIAL_LAT);

        // Output held while out_ready is low.
        out_ready = 1'b0;
        op        = OP_MUL;
        operand_a = 32'd6;
        operand_b = 32'd7;
        rd_in     = 5'd13;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("hold valid", 32'(out_valid), 32'd1);
        check("hold result", out_result, 32'd42);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold valid stable", 32'(out_valid), 32'd1);
            check("hold result stable", out_result, 32'd42);
            check("hold rd stable", 32'(out_rd), 32'd13);
            check("hold in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("release valid", 32'(out_valid), 32'd0);
        check("release busy", 32'(busy), 32'd0);

        // Flush at divide step 10.
        op        = OP_DIV;
        operand_a = 32'd100;
        operand_b = 32'd7;
        rd_in     = 5'd14;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("flush busy", 32'(busy), 32'd0);
        check("flush valid", 32'(out_valid), 32'd0);
        check("flush in_ready", 32'(in_ready), 32'd1);
        saw_valid = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid === 1'b1) saw_valid = 1'b1;
        end
        check("flush no result", 32'(saw_valid), 32'd0);
        run_op("div93", OP_DIV, 32'd9, 32'd3, 5'd15, 32'd3, 33);

        // Asynchronous reset at divide step 20.
        op        = OP_DIV;
        operand_a = 32'd100;
        operand_b = 32'd7;
        rd_in     = 5'd16;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        held_result = out_result;
        check("pre-rst result", held_result, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst valid", 32'(out_valid), 32'd0);
        check("mid rst result", out_result, 32'd0);
        check("mid rst rd", 32'(out_rd), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Flush with in_valid in the same cycle accepts nothing.
        flush     = 1'b1;
        op        = OP_DIV;
        operand_a = 32'd9;
        operand_b = 32'd3;
        rd_in     = 5'd17;
        in_valid  = 1'b1;
        #1;
        check("flush+valid in_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush+valid busy", 32'(busy), 32'd0);
        tick();
        check("flush+valid no result", 32'(out_valid), 32'd0);

        run_op("final mul", OP_MUL, 32'd12, 32'd12, 5'd18, 32'd144, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
